// File: rtl/pipe_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_shifter
//  Description : Pipelined barrel shifter (SHL / SHR / ASHR / ROL) with a
//                valid/ready handshake, whole-pipeline back-pressure and a
//                left-shift overflow flag. One stage per shift-amount bit,
//                so the latency is $clog2(DATAWIDTH) cycles.
//  Options     : SHIFTER_ROTATE_EN - define to build the rotate-left path.
//                When undefined, mode 2'b11 behaves exactly like SHL.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_shifter #(
   parameter int DATAWIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [DATAWIDTH-1:0] a,
   input  logic [DATAWIDTH-1:0] sh_amt,
   input  logic [1:0]           mode,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [DATAWIDTH-1:0] d,
   output logic                 out_ovf
);

   localparam int SHW = $clog2(DATAWIDTH);

   localparam logic [1:0] C_MODE_SHL  = 2'b00;
   localparam logic [1:0] C_MODE_SHR  = 2'b01;
   localparam logic [1:0] C_MODE_ASHR = 2'b10;
   localparam logic [1:0] C_MODE_ROL  = 2'b11;

   // The whole pipeline advances together; a stalled output freezes every stage.
   logic w_en;
   assign w_en     = !out_valid || out_ready;
   assign in_ready = w_en;

   for (genvar k = 0; k < SHW; k++) begin : g_stage
      localparam int C_SH   = 1 << k;       // shift distance of this stage
      localparam int C_AW   = SHW - k;      // shift-amount bits still pending
      localparam bit C_LAST = (k == SHW - 1);

      // stage inputs (from the ports for stage 0, otherwise from stage k-1)
      logic [DATAWIDTH-1:0] w_din;
      logic [C_AW-1:0]      w_amt;
      logic [1:0]           w_mode;
      logic                 w_vin;
      logic                 w_big;
      logic                 w_ovf_in;

      // stage datapath
      logic [DATAWIDTH-1:0] w_shifted;
      logic                 w_lost;
      logic [DATAWIDTH-1:0] data_d;
      logic                 ovf_d;

      // stage registers
      logic [DATAWIDTH-1:0] data_q;
      logic                 valid_q;
      logic                 ovf_q;

      if (k == 0) begin : g_src_port
         assign w_din    = a;
         assign w_amt    = sh_amt[SHW-1:0];
         assign w_vin    = in_valid;
         assign w_big    = |sh_amt[DATAWIDTH-1:SHW];
         assign w_ovf_in = 1'b0;
`ifdef SHIFTER_ROTATE_EN
         assign w_mode   = mode;
`else
         // No rotate hardware: fold mode 11 onto SHL once, at the entry.
         assign w_mode   = (mode == C_MODE_ROL) ? C_MODE_SHL : mode;
`endif
      end else begin : g_src_prev
         assign w_din    = g_stage[k-1].data_q;
         assign w_amt    = g_stage[k-1].g_fwd.amt_q;
         assign w_vin    = g_stage[k-1].valid_q;
         assign w_big    = g_stage[k-1].g_fwd.big_q;
         assign w_ovf_in = g_stage[k-1].ovf_q;
         assign w_mode   = g_stage[k-1].g_fwd.mode_q;
      end

      // Conditional shift by 2^k; for SHL also note whether ones fall off the top.
      always_comb begin
         w_shifted = w_din;
         w_lost    = 1'b0;
         if (w_amt[0]) begin
            case (w_mode)
               C_MODE_SHL: begin
                  w_shifted = w_din << C_SH;
                  w_lost    = |w_din[DATAWIDTH-1 -: C_SH];
               end
               C_MODE_SHR:  w_shifted = w_din >> C_SH;
               C_MODE_ASHR: w_shifted = $signed(w_din) >>> C_SH;
`ifdef SHIFTER_ROTATE_EN
               C_MODE_ROL:  w_shifted = (w_din << C_SH) | (w_din >> (DATAWIDTH - C_SH));
`endif
               default:     w_shifted = w_din;
            endcase
         end
      end

      // Final stage resolves shifts of DATAWIDTH or more; the sign bit survives
      // every ASHR step, so w_din's MSB is still the original sign here.
      always_comb begin
         data_d = w_shifted;
         if (C_LAST && w_big) begin
            case (w_mode)
               C_MODE_SHL,
               C_MODE_SHR:  data_d = '0;
               C_MODE_ASHR: data_d = {DATAWIDTH{w_din[DATAWIDTH-1]}};
               default:     data_d = w_shifted;
            endcase
         end
         // Any surviving one is lost on a big SHL; earlier losses are accumulated.
         ovf_d = (w_mode == C_MODE_SHL) &&
                 (w_ovf_in || w_lost || (C_LAST && w_big && (|w_shifted)));
      end

      // Stage register for data, valid and overflow; bubbles travel as-is.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            valid_q <= 1'b0;
            data_q  <= '0;
            ovf_q   <= 1'b0;
         end else if (w_en) begin
            valid_q <= w_vin;
            data_q  <= data_d;
            ovf_q   <= ovf_d;
         end
      end

      if (!C_LAST) begin : g_fwd
         logic [C_AW-2:0] amt_q;
         logic [1:0]      mode_q;
         logic            big_q;

         // Control that later stages still need: remaining amount bits, mode, big-shift.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               amt_q  <= '0;
               mode_q <= C_MODE_SHL;
               big_q  <= 1'b0;
            end else if (w_en) begin
               amt_q  <= w_amt[C_AW-1:1];
               mode_q <= w_mode;
               big_q  <= w_big;
            end
         end
      end
   end

   assign out_valid = g_stage[SHW-1].valid_q;
   assign d         = g_stage[SHW-1].data_q;
   assign out_ovf   = g_stage[SHW-1].ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_shifter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_shifter
//  Description : Scoreboard bench for pipe_shifter (DATAWIDTH = 32).
//                Expected results are queued on input accept and compared
//                on output handshake. Honours SHIFTER_ROTATE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_shifter;

   localparam int W   = 32;
   localparam int LAT = 5;

   logic         clk       = 1'b0;
   logic         rst_n     = 1'b0;
   logic         in_valid  = 1'b0;
   logic         in_ready;
   logic [W-1:0] a         = '0;
   logic [W-1:0] sh_amt    = '0;
   logic [1:0]   mode      = 2'b00;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [W-1:0] d;
   logic         out_ovf;

   typedef struct {
      string        tag;
      logic [W-1:0] d;
      logic         ovf;
      int           acc;
   } exp_t;

   exp_t sb[$];
   int   n_checks  = 0;
   int   n_pass    = 0;
   int   cyc       = 0;
   int   last_lat  = -1;
   bit   saw_valid = 1'b0;

   pipe_shifter #(.DATAWIDTH(W)) dut (
      .clk       (clk),
      .rst       (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .sh_amt    (sh_amt),
      .mode      (mode),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .d         (d),
      .out_ovf   (out_ovf)
   );

   always #5 clk = ~clk;

   // edge counter used for latency measurement
   always @(posedge clk) cyc++;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   // Independent reference: straight-line operators on the whole operand.
   function automatic void model(input logic [W-1:0] av, input logic [W-1:0] sv,
                                 input logic [1:0] mv, output logic [W-1:0] rd,
                                 output logic ro);
      logic [1:0]     m;
      logic [2*W-1:0] wide;
      int             r;
      m = mv;
`ifndef SHIFTER_ROTATE_EN
      if (m == 2'b11) m = 2'b00;
`endif
      rd = av;
      ro = 1'b0;
      case (m)
         2'b00: begin
            if (sv >= W) begin
               rd = '0;
               ro = (av != '0);
            end else begin
               wide = {{W{1'b0}}, av} << sv;
               rd   = wide[W-1:0];
               ro   = (wide[2*W-1:W] != '0);
            end
         end
         2'b01: begin
            if (sv >= W) rd = '0;
            else         rd = av >> sv;
         end
         2'b10: begin
            if (sv >= W) rd = {W{av[W-1]}};
            else         rd = $signed(av) >>> sv;
         end
         default: begin
            r  = int'(sv % W);
            rd = (av << r) | (av >> (W - r));
         end
      endcase
   endfunction

   // Present one operand and hold it until accepted; queue its expectation.
   task automatic send(input string tag, input logic [W-1:0] av, input logic [W-1:0] sv,
                       input logic [1:0] mv, input logic [W-1:0] ed, input logic eo);
      bit   done;
      exp_t e;
      done     = 1'b0;
      in_valid = 1'b1;
      a        = av;
      sh_amt   = sv;
      mode     = mv;
      for (int t = 0; t < 200 && !done; t++) begin
         @(negedge clk);
         if (in_ready) begin
            done  = 1'b1;
            e.tag = tag;
            e.d   = ed;
            e.ovf = eo;
            e.acc = cyc;
            sb.push_back(e);
         end
         @(posedge clk);
         #1;
      end
      if (!done) check({tag, ".accept_timeout"}, 64'd0, 64'd1);
   endtask

   task automatic send_rand(input string tag);
      logic [W-1:0] ra, rs, ed;
      logic [1:0]   rm;
      logic         eo;
      ra = $urandom;
      rs = W'($urandom_range(0, 40));
      rm = 2'($urandom_range(0, 3));
      model(ra, rs, rm, ed, eo);
      send(tag, ra, rs, rm, ed, eo);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int t;
      t = 0;
      while (sb.size() != 0 && t < 100) begin
         @(posedge clk);
         #1;
         t++;
      end
      check({tag, ".drain"}, 64'(sb.size()), 64'd0);
   endtask

   // Output monitor: every handshake must match the oldest queued expectation.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (out_valid) saw_valid = 1'b1;
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_out", 64'(out_valid), 64'd0);
            end else begin
               e = sb.pop_front();
               check({e.tag, ".d"}, 64'(d), 64'(e.d));
               check({e.tag, ".ovf"}, 64'(out_ovf), 64'(e.ovf));
               last_lat = cyc - e.acc;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] held;
      bit           ok;

      // ---- reset state ----
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.d",         64'(d),         64'd0);
      check("rst.out_ovf",   64'(out_ovf),   64'd0);
      check("rst.in_ready",  64'(in_ready),  64'd1);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // ---- SHL basic with latency ----
      send("shl_basic", 32'h0000_00F1, 32'd4, 2'b00, 32'h0000_0F10, 1'b0);
      idle();
      drain("shl_basic");
      check("shl_basic.latency", 64'(last_lat), 64'(LAT));

      // ---- directed boundary cases, back to back ----
      send("shl_1",   32'h8000_0001, 32'd1,  2'b00, 32'h0000_0002, 1'b1);
      send("shl_32",  32'h8000_0001, 32'd32, 2'b00, 32'h0000_0000, 1'b1);
      send("shl_0",   32'h8000_0001, 32'd0,  2'b00, 32'h8000_0001, 1'b0);
      send("shr_31",  32'h8000_0000, 32'd31, 2'b01, 32'h0000_0001, 1'b0);
      send("ashr_31", 32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF, 1'b0);
      send("ashr_40", 32'h8000_0000, 32'd40, 2'b10, 32'hFFFF_FFFF, 1'b0);
      send("shr_40",  32'h8000_0000, 32'd40, 2'b01, 32'h0000_0000, 1'b0);
      send("ashr_0",  32'h8000_0001, 32'd0,  2'b10, 32'h8000_0001, 1'b0);
      send("m11_0",   32'h8000_0001, 32'd0,  2'b11, 32'h8000_0001, 1'b0);
`ifdef SHIFTER_ROTATE_EN
      send("rol_1",   32'h8000_0001, 32'd1,  2'b11, 32'h0000_0003, 1'b0);
      send("rol_33",  32'h8000_0001, 32'd33, 2'b11, 32'h0000_0003, 1'b0);
`else
      send("m11_1",   32'h8000_0001, 32'd1,  2'b11, 32'h0000_0002, 1'b1);
      send("m11_33",  32'h8000_0001, 32'd33, 2'b11, 32'h0000_0000, 1'b1);
`endif
      idle();
      drain("directed");

      // ---- back-pressure: 8 random ops, 4-cycle output stall ----
      fork
         begin
            for (int i = 0; i < 8; i++) send_rand($sformatf("bp%0d", i));
            idle();
         end
         begin
            ok = 1'b0;
            for (int t = 0; t < 100 && !ok; t++) begin
               @(negedge clk);
               ok = out_valid;
            end
            check("bp.wait_valid", 64'(ok), 64'd1);
            @(posedge clk);
            #1;
            out_ready = 1'b0;
            @(negedge clk);
            held = d;
            for (int s = 0; s < 4; s++) begin
               if (s > 0) @(negedge clk);
               check("bp.in_ready_stalled", 64'(in_ready),  64'd0);
               check("bp.out_valid_held",   64'(out_valid), 64'd1);
               check("bp.d_held",           64'(d),         64'(held));
            end
            @(posedge clk);
            #1;
            out_ready = 1'b1;
            @(negedge clk);
            check("bp.in_ready_resumed", 64'(in_ready), 64'd1);
         end
      join
      drain("bp");

      // ---- reset with three operations in flight ----
      out_ready = 1'b0;
      send("inflt0", 32'h8000_0001, 32'd1, 2'b00, 32'h0000_0002, 1'b1);
      send("inflt1", 32'h0000_00FF, 32'd4, 2'b01, 32'h0000_000F, 1'b0);
      send("inflt2", 32'h1234_5678, 32'd8, 2'b10, 32'h0012_3456, 1'b0);
      idle();
      ok = 1'b0;
      for (int t = 0; t < 50 && !ok; t++) begin
         @(negedge clk);
         ok = out_valid;
      end
      check("inflt.valid_before_rst", 64'(ok), 64'd1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst.out_valid", 64'(out_valid), 64'd0);
      check("midrst.d",         64'(d),         64'd0);
      check("midrst.out_ovf",   64'(out_ovf),   64'd0);
      check("midrst.in_ready",  64'(in_ready),  64'd1);
      sb.delete();
      out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n     = 1'b1;
      saw_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      check("midrst.no_stale", 64'(saw_valid), 64'd0);

      send("post_rst", 32'h1234_5678, 32'd8, 2'b01, 32'h0012_3456, 1'b0);
      idle();
      drain("post_rst");
      check("post_rst.latency", 64'(last_lat), 64'(LAT));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
